// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
//   Shared types and constants for the candy vending controller.
//   - state_t        : controller state (IDLE collects credit, VEND holds outputs)
//   - CREDIT_W       : width of the credit register in cents
//   - NICKEL_C/DIME_C/QUARTER_C : coin values in cents
//   - change_dimes / change_nickel : split a change amount (multiple of 5,
//     at most 20) into dimes plus at most one nickel
// -----------------------------------------------------------------------------
package vending_pkg;

  localparam int CREDIT_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    VEND = 1'b1
  } state_t;

  localparam logic [CREDIT_W-1:0] NICKEL_C  = 6'd5;
  localparam logic [CREDIT_W-1:0] DIME_C    = 6'd10;
  localparam logic [CREDIT_W-1:0] QUARTER_C = 6'd25;

  // Change never exceeds 20c, so comparisons replace a divide-by-10.
  function automatic logic [1:0] change_dimes(input logic [CREDIT_W-1:0] chg);
    if (chg >= 6'd20) begin
      return 2'd2;
    end else if (chg >= 6'd10) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

  // Whatever is left after the dimes is either 0c or 5c.
  function automatic logic change_nickel(input logic [CREDIT_W-1:0] chg);
    logic [CREDIT_W-1:0] rem;
    case (change_dimes(chg))
      2'd2:    rem = chg - 6'd20;
      2'd1:    rem = chg - 6'd10;
      default: rem = chg;
    endcase
    return (rem >= 6'd5);
  endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// -----------------------------------------------------------------------------
// coin_edge_detect
//   Turns one coin-sensor level into a single-cycle pulse on its 0->1 edge.
//   A coin held high for many cycles produces one pulse. The history flop
//   clears to 0 on reset, so a coin already high at reset release still
//   produces a pulse.
//   Configuration macro: INPUT_SYNC_EN -- when defined, the level first goes
//   through a two-flop synchronizer (adds 2 cycles of latency).
// Ports
//   clk    in  1  system clock, rising edge
//   reset  in  1  asynchronous, active-low reset
//   din    in  1  coin sensor level
//   pulse  out 1  high for one cycle per rising edge of the (synced) level
// -----------------------------------------------------------------------------
module coin_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic level;
  logic prev;

`ifdef INPUT_SYNC_EN
  input_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .dout  (level)
  );
`else
  assign level = din;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/input_sync.sv
// -----------------------------------------------------------------------------
// input_sync
//   Two-flop synchronizer for one asynchronous sensor level. Both flops
//   clear to 0 on reset. Only instantiated when INPUT_SYNC_EN is defined.
// Ports
//   clk    in  1  system clock, rising edge
//   reset  in  1  asynchronous, active-low reset
//   din    in  1  raw asynchronous input
//   dout   out 1  synchronized level (2 cycles behind din)
// -----------------------------------------------------------------------------
module input_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/vending_machine_core.sv
// -----------------------------------------------------------------------------
// vending_machine_core
//   Coin-operated candy vending controller. Accumulates credit from nickel,
//   dime and quarter pulses; once credit reaches PRICE it dispenses one candy
//   and returns change as dimes plus at most one nickel, holding those outputs
//   until the customer acknowledges with thanks_in.
//   Configuration macro: INPUT_SYNC_EN -- when defined, all four inputs pass
//   through two-flop synchronizers (2 extra cycles of latency).
// Parameters
//   PRICE       candy price in cents; multiple of 5, 5..35
// Ports
//   clk         in  1  system clock, rising edge
//   reset       in  1  asynchronous, active-low reset
//   nickel_in   in  1  nickel sensor level (5c on 0->1 edge)
//   dime_in     in  1  dime sensor level (10c on 0->1 edge)
//   quarter_in  in  1  quarter sensor level (25c on 0->1 edge)
//   thanks_in   in  1  customer acknowledge; ends a vend
//   candy_out   out 1  dispense candy; high throughout VEND
//   nickel_out  out 1  return one nickel; valid throughout VEND
//   dime_out    out 2  number of dimes returned (0..2); valid throughout VEND
// -----------------------------------------------------------------------------
module vending_machine_core
  import vending_pkg::*;
#(
  parameter int unsigned PRICE = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       quarter_in,
  input  logic       thanks_in,
  output logic       candy_out,
  output logic       nickel_out,
  output logic [1:0] dime_out
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  logic nickel_evt;
  logic dime_evt;
  logic quarter_evt;
  logic thanks_s;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          dimes_q, dimes_d;
  logic                nickel_q, nickel_d;

  logic [CREDIT_W-1:0] coin_value;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] chg;

  coin_edge_detect u_nickel (
    .clk   (clk),
    .reset (reset),
    .din   (nickel_in),
    .pulse (nickel_evt)
  );

  coin_edge_detect u_dime (
    .clk   (clk),
    .reset (reset),
    .din   (dime_in),
    .pulse (dime_evt)
  );

  coin_edge_detect u_quarter (
    .clk   (clk),
    .reset (reset),
    .din   (quarter_in),
    .pulse (quarter_evt)
  );

  // thanks_in is a level, so it only gets the synchronizer, not an edge pulse.
`ifdef INPUT_SYNC_EN
  input_sync u_thanks_sync (
    .clk   (clk),
    .reset (reset),
    .din   (thanks_in),
    .dout  (thanks_s)
  );
`else
  assign thanks_s = thanks_in;
`endif

  // Coins arriving in the same cycle: only the most valuable one is credited.
  always_comb begin
    coin_value = '0;
    if (quarter_evt) begin
      coin_value = QUARTER_C;
    end else if (dime_evt) begin
      coin_value = DIME_C;
    end else if (nickel_evt) begin
      coin_value = NICKEL_C;
    end
  end

  // State register, together with the credit and latched change amounts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      dimes_q  <= 2'd0;
      nickel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      dimes_q  <= dimes_d;
      nickel_q <= nickel_d;
    end
  end

  // Next-state logic. Credit stays below PRICE (<= 30) in IDLE, so adding a
  // quarter peaks at 55 and never overflows the 6-bit sum.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    dimes_d  = dimes_q;
    nickel_d = nickel_q;
    sum      = credit_q + coin_value;
    chg      = sum - PRICE_C;
    case (state_q)
      IDLE: begin
        if (coin_value != '0) begin
          if (sum < PRICE_C) begin
            credit_d = sum;
          end else begin
            state_d  = VEND;
            credit_d = '0;
            dimes_d  = change_dimes(chg);
            nickel_d = change_nickel(chg);
          end
        end
      end
      VEND: begin
        // Coins are ignored while vending; the edge history still advances,
        // so a coin landing with thanks is simply lost.
        if (thanks_s) begin
          state_d  = IDLE;
          credit_d = '0;
          dimes_d  = 2'd0;
          nickel_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
        dimes_d  = 2'd0;
        nickel_d = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers; change regs are zero outside VEND.
  always_comb begin
    candy_out  = (state_q == VEND);
    nickel_out = nickel_q;
    dime_out   = dimes_q;
  end

endmodule

// File: tb/tb_vending_machine_core.sv
// -----------------------------------------------------------------------------
// tb_vending_machine_core
//   Directed self-checking bench for vending_machine_core at PRICE = 15.
//   Inputs change on falling clock edges; outputs are sampled on falling edges.
//   Each check compares {candy_out, nickel_out, dime_out} to a hand-computed
//   4-bit value.
// -----------------------------------------------------------------------------
module tb_vending_machine_core;

  logic       clk = 1'b1;
  logic       reset;
  logic       nickel_in;
  logic       dime_in;
  logic       quarter_in;
  logic       thanks_in;
  logic       candy_out;
  logic       nickel_out;
  logic [1:0] dime_out;

  int checks   = 0;
  int failures = 0;

  localparam int NICKEL  = 0;
  localparam int DIME    = 1;
  localparam int QUARTER = 2;
  localparam int NIC_QTR = 3;

  vending_machine_core #(.PRICE(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .nickel_in  (nickel_in),
    .dime_in    (dime_in),
    .quarter_in (quarter_in),
    .thanks_in  (thanks_in),
    .candy_out  (candy_out),
    .nickel_out (nickel_out),
    .dime_out   (dime_out)
  );

  // Rising edges at 10, 20, 30 ... so the 125 ns reset release sits on a falling edge.
  always #5 clk = ~clk;

  // Raise a coin sensor for 'hold' cycles, drop it, then idle one cycle so
  // the edge history sees a low before the next coin.
  task automatic drive_coin(input int which, input int hold);
    case (which)
      NICKEL:  nickel_in = 1'b1;
      DIME:    dime_in = 1'b1;
      QUARTER: quarter_in = 1'b1;
      default: begin
        nickel_in  = 1'b1;
        quarter_in = 1'b1;
      end
    endcase
    repeat (hold) @(negedge clk);
    nickel_in  = 1'b0;
    dime_in    = 1'b0;
    quarter_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_thanks();
    thanks_in = 1'b1;
    @(negedge clk);
    thanks_in = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    nickel_in  = 1'b0;
    dime_in    = 1'b0;
    quarter_in = 1'b0;
    thanks_in  = 1'b0;
    #50;
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_held actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    #75;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_release actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
  endtask

  task automatic test_dime_dime();
    drive_coin(DIME, 2);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL dd_first actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    drive_coin(DIME, 2);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL dd_vend actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1100);
    end
  endtask

  task automatic test_vend_hold();
    drive_coin(QUARTER, 1);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL vend_hold actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1100);
    end
    do_thanks();
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL thanks_clear actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    drive_coin(DIME, 1);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL credit10_novend actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    drive_coin(NICKEL, 1);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL credit10_plus5 actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1000);
    end
    do_thanks();
  endtask

  task automatic test_quarter();
    drive_coin(QUARTER, 2);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL quarter_vend actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1001);
    end
    do_thanks();
  endtask

  task automatic test_dime_quarter();
    drive_coin(DIME, 2);
    drive_coin(QUARTER, 2);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL dq_vend actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1010);
    end
    do_thanks();
  endtask

  task automatic test_nickels();
    drive_coin(NICKEL, 10);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL held_nickel actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    drive_coin(NICKEL, 2);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL nickel2 actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    drive_coin(NICKEL, 2);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL nickel3_vend actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1000);
    end
    do_thanks();
  endtask

  task automatic test_reset_mid();
    drive_coin(DIME, 2);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive_coin(NICKEL, 2);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_lost_credit actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    // credit 5 + quarter only = 30 -> 15c change = one dime + one nickel
    drive_coin(NIC_QTR, 2);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1101) begin
      failures++;
      $display("[TB] FAIL simul_coins actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1101);
    end
    // Asynchronous reset during VEND clears outputs before any clock edge.
    reset = 1'b0;
    #1;
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_coin(QUARTER, 1);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1001) begin
      failures++;
      $display("[TB] FAIL b2b_vend actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1001);
    end
    // Quarter arriving with thanks is discarded.
    quarter_in = 1'b1;
    thanks_in  = 1'b1;
    @(negedge clk);
    quarter_in = 1'b0;
    thanks_in  = 1'b0;
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL b2b_thanks actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    @(negedge clk);
    drive_coin(DIME, 1);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL b2b_dime actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b0000);
    end
    drive_coin(NICKEL, 1);
    checks++;
    if ({candy_out, nickel_out, dime_out} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL b2b_nickel actual=%b expected=%b", {candy_out, nickel_out, dime_out}, 4'b1000);
    end
    do_thanks();
  endtask

  initial begin
    test_reset();
    test_dime_dime();
    test_vend_hold();
    test_quarter();
    test_dime_quarter();
    test_nickels();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
